// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic units (subtractor and sibling adder).
package serial_subtractor_pkg;

    localparam int SUB_DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result buses of the serial subtractor.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout is the borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell, WIDTH cycles per a - b.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_r_q, borrow_r_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cell_d, cell_bout;

    full_subtractor u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_r_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        d_sh_d     = d_sh_q;
        cnt_d      = cnt_q;
        borrow_r_d = borrow_r_q;
        a_msb_d    = a_msb_q;
        b_msb_d    = b_msb_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_RUN;
                    a_sh_d     = bus.a;
                    b_sh_d     = bus.b;
                    a_msb_d    = bus.a[WIDTH-1];
                    b_msb_d    = bus.b[WIDTH-1];
                    borrow_r_d = 1'b0;
                    cnt_d      = '0;
                end
            end
            S_RUN: begin
                a_sh_d     = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d     = {1'b0, b_sh_q[WIDTH-1:1]};
                d_sh_d     = {cell_d, d_sh_q[WIDTH-1:1]};
                borrow_r_d = cell_bout;
                cnt_d      = cnt_q + CW'(1);
                // The last cell output is the result MSB, so publish straight from the cell.
                if (cnt_q == CNT_LAST) begin
                    state_d    = S_DONE;
                    diff_d     = {cell_d, d_sh_q[WIDTH-1:1]};
                    borrow_d   = cell_bout;
                    overflow_d = (a_msb_q ^ b_msb_q) & (cell_d ^ a_msb_q);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            d_sh_q     <= '0;
            cnt_q      <= '0;
            borrow_r_q <= 1'b0;
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            d_sh_q     <= d_sh_d;
            cnt_q      <= cnt_d;
            borrow_r_q <= borrow_r_d;
            a_msb_q    <= a_msb_d;
            b_msb_q    <= b_msb_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.diff     = diff_q;
    assign bus.borrow   = borrow_q;
    assign bus.overflow = overflow_q;

endmodule
